// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, states,
// ALUOp and ALUControl codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decode: (ALUOp, funct) -> ALUControl, plus a flag for unsupported functs.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic [2:0] ALUControl,
    output logic       bad_funct
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Judged on funct alone so DECODE (where ALUOp is 00) can flag a bad R-type early.
    always_comb begin
        bad_funct = 1'b1;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: bad_funct = 1'b0;
            default:                               bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore main controller for the multicycle MIPS core, with memory wait handshake.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state, w_next;
    logic [1:0] w_aluop;
    logic       w_pcwrite, w_branch, w_irwrite, w_regwrite, w_memwrite, w_illegal;
    logic       w_bad_funct;

    mips_alu_decoder u_alu_dec (
        .ALUOp      (w_aluop),
        .funct      (funct),
        .ALUControl (ALUControl),
        .bad_funct  (w_bad_funct)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_aluop    = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        w_next    = S_EXECUTE;
                        w_illegal = w_bad_funct;
                    end
                    OP_BEQ:  w_next = S_BRANCH;
                    OP_ADDI: w_next = S_ADDIEX;
                    OP_J:    w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW)      w_next = S_MEMREAD;
                else if (opcode == OP_SW) w_next = S_MEMWRITE;
                else                      w_next = S_FETCH;
            end
            S_MEMREAD: begin
                IorD   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_aluop  = ALUOP_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are gated by reset so nothing commits while the core is held.
    assign IRWrite    = reset & w_irwrite;
    assign RegWrite   = reset & w_regwrite;
    assign MemWrite   = reset & w_memwrite;
    assign illegal_op = reset & w_illegal;
    assign PCEn       = reset & (w_pcwrite | (w_branch & zero));
    assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for the multicycle MIPS controller.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, illegal_op;
    logic [3:0] state;

    int n_chk = 0;
    int n_err = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then let combinational outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle_en(input string tag);
        chk({tag, ".IRWrite"},  IRWrite,    0);
        chk({tag, ".PCEn"},     PCEn,       0);
        chk({tag, ".RegWrite"}, RegWrite,   0);
        chk({tag, ".MemWrite"}, MemWrite,   0);
        chk({tag, ".illegal"},  illegal_op, 0);
    endtask

    initial begin
        reset = 1'b0; opcode = 6'b000000; funct = 6'b101010; zero = 1'b0; mem_ready = 1'b1;
        #12;
        chk("rst.state", state, 0);
        chk_idle_en("rst");
        chk("rst.IorD", IorD, 0);
        chk("rst.ALUSrcB", ALUSrcB, 2'b01);
        tick();
        reset = 1'b1; #1;
        chk("rel.IRWrite", IRWrite, 1);
        chk("rel.PCEn", PCEn, 1);

        // R-type slt
        tick();
        chk("slt.dec.state", state, 1);
        chk("slt.dec.ALUSrcB", ALUSrcB, 2'b11);
        chk("slt.dec.illegal", illegal_op, 0);
        tick();
        chk("slt.ex.state", state, 6);
        chk("slt.ex.ALUCtl", ALUControl, 3'b111);
        chk("slt.ex.ALUSrcA", ALUSrcA, 1);
        chk("slt.ex.ALUSrcB", ALUSrcB, 2'b00);
        tick();
        chk("slt.wb.state", state, 7);
        chk("slt.wb.RegDst", RegDst, 1);
        chk("slt.wb.RegWrite", RegWrite, 1);
        tick();
        chk("slt.end.state", state, 0);

        // R-type sub, then reset mid-EXECUTE
        funct = 6'b100010;
        tick(); tick();
        chk("sub.ex.state", state, 6);
        chk("sub.ex.ALUCtl", ALUControl, 3'b110);
        reset = 1'b0; #1;
        chk("midrst.state", state, 0);
        chk_idle_en("midrst");
        tick();
        chk("midrst.hold.state", state, 0);
        chk_idle_en("midrst.hold");
        reset = 1'b1; #1;
        chk("rel2.IRWrite", IRWrite, 1);
        chk("rel2.PCEn", PCEn, 1);

        // lw: 0,1,2,3,4,0
        opcode = 6'b100011;
        tick();
        chk("lw.s1", state, 1);
        chk("lw.s1.RegWrite", RegWrite, 0);
        tick();
        chk("lw.s2", state, 2);
        chk("lw.s2.ALUSrcA", ALUSrcA, 1);
        chk("lw.s2.ALUSrcB", ALUSrcB, 2'b10);
        chk("lw.s2.ALUCtl", ALUControl, 3'b010);
        tick();
        chk("lw.s3", state, 3);
        chk("lw.s3.IorD", IorD, 1);
        chk("lw.s3.RegWrite", RegWrite, 0);
        chk("lw.s3.MemtoReg", MemtoReg, 0);
        tick();
        chk("lw.s4", state, 4);
        chk("lw.s4.RegWrite", RegWrite, 1);
        chk("lw.s4.MemtoReg", MemtoReg, 1);
        chk("lw.s4.RegDst", RegDst, 0);
        tick();
        chk("lw.s0", state, 0);
        chk("lw.s0.RegWrite", RegWrite, 0);

        // sw with 3 wait cycles in MEMWRITE
        opcode = 6'b101011;
        tick(); tick();
        chk("sw.s2", state, 2);
        chk("sw.s2.RegWrite", RegWrite, 0);
        tick();
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready = 1'b1; #1; end
            chk("sw.wait.state", state, 5);
            chk("sw.wait.MemWrite", MemWrite, 1);
            chk("sw.wait.IorD", IorD, 1);
            chk("sw.wait.RegWrite", RegWrite, 0);
            tick();
        end
        chk("sw.end.state", state, 0);
        chk("sw.end.MemWrite", MemWrite, 0);

        // beq taken / not taken
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            tick(); tick();
            chk("beq.state", state, 8);
            chk("beq.PCEn", PCEn, z);
            chk("beq.PCSrc", PCSrc, 2'b01);
            chk("beq.ALUCtl", ALUControl, 3'b110);
            tick();
            chk("beq.end.state", state, 0);
        end
        zero = 1'b0;

        // Illegal opcode
        opcode = 6'b111111;
        tick();
        chk("ill.dec.state", state, 1);
        chk("ill.dec.illegal", illegal_op, 1);
        chk("ill.dec.RegWrite", RegWrite, 0);
        chk("ill.dec.MemWrite", MemWrite, 0);
        tick();
        chk("ill.next.state", state, 0);
        chk("ill.next.illegal", illegal_op, 0);

        // R-type with unsupported funct: flagged, still executes as add
        opcode = 6'b000000; funct = 6'b000111;
        tick();
        chk("badfn.dec.illegal", illegal_op, 1);
        tick();
        chk("badfn.ex.state", state, 6);
        chk("badfn.ex.ALUCtl", ALUControl, 3'b010);
        chk("badfn.ex.illegal", illegal_op, 0);
        tick(); tick();
        chk("badfn.end.state", state, 0);

        // j
        opcode = 6'b000010;
        tick(); tick();
        chk("j.state", state, 11);
        chk("j.PCSrc", PCSrc, 2'b10);
        chk("j.PCEn", PCEn, 1);
        tick();
        chk("j.end.state", state, 0);

        // addi
        opcode = 6'b001000;
        tick(); tick();
        chk("addi.ex.state", state, 9);
        chk("addi.ex.ALUSrcB", ALUSrcB, 2'b10);
        chk("addi.ex.ALUCtl", ALUControl, 3'b010);
        tick();
        chk("addi.wb.state", state, 10);
        chk("addi.wb.RegWrite", RegWrite, 1);
        chk("addi.wb.RegDst", RegDst, 0);
        chk("addi.wb.MemtoReg", MemtoReg, 0);
        tick();
        chk("addi.end.state", state, 0);

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0; #1;
        chk("fetch.stall.IRWrite", IRWrite, 0);
        chk("fetch.stall.PCEn", PCEn, 0);
        tick();
        chk("fetch.stall.state", state, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
